axis_seq_checker: RTL
=====================

Name: axis_seq_checker

Overview:
- AXI-Stream sink that sits directly downstream of the FIFO-to-stream adapter, in the consumer position.
- Accepts beats with optional pseudo-random backpressure.
- Checks that the data forms an incrementing sequence and that tlast sits on fixed frame boundaries.
- Exposes beat, frame and error counters for the testbench and for on-chip status.

Parameters:
DATA_W, 8, tdata width in bits
FRAME_LEN, 16, beats per frame; tlast required on the last beat of each frame (>=1)
SYNC_FIRST, 1, 1 = first accepted beat after reset seeds the expected value without error; 0 = expected starts at 0
LFSR_SEED, 8'hA5, reset value of the backpressure LFSR (must be non-zero)

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
s_tdata  input  DATA_W  stream data
s_tvalid  input  1  stream valid
s_tlast  input  1  stream end-of-frame marker
s_tready  output  1  stream ready, registered
bp_en  input  1  1 = pseudo-random backpressure, 0 = always ready
beat_count  output  32  accepted beats, wraps at 2^32
frame_count  output  16  accepted beats with s_tlast=1, wraps
data_err_count  output  16  data mismatches, saturates at 16'hFFFF
last_err_count  output  16  tlast misplacements, saturates at 16'hFFFF
error_flag  output  1  sticky; set on any error, cleared only by reset
last_data  output  DATA_W  tdata of the most recent accepted beat

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, and takes effect immediately.
- Reset values:
  - s_tready=0; all counters 0; error_flag=0; last_data=0.
  - expected=0; beat index=0; LFSR=LFSR_SEED; state=SYNC (state=RUN if SYNC_FIRST=0).
- Handshake:
  - A beat is accepted on a rising edge where s_tvalid && s_tready.
  - s_tready never depends combinationally on s_tvalid.
  - The upstream block holds tdata, tlast and tvalid until the beat is accepted; the checker does not check this.
- Backpressure:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifts every cycle after reset.
  - Next s_tready = bp_en ? (lfsr[1:0] != 2'b00) : 1.
  - Consequence: the first cycle after reset release has s_tready=0; it reaches 1 on the next edge when bp_en=0.
- State machine:
  - SYNC: on an accepted beat, expected <= tdata+1, no data check; go to RUN.
  - RUN: on an accepted beat, compare tdata with expected.
    - Mismatch: data_err_count++ (saturating), error_flag<=1, expected<=tdata+1 (resync).
    - Match: expected<=expected+1.
  - Arithmetic is mod 2^DATA_W, so 0xFF followed by 0x00 is a match for DATA_W=8.
- tlast check (both states):
  - beat index counts 0..FRAME_LEN-1 over accepted beats.
  - Required: s_tlast == (index==FRAME_LEN-1).
  - Any violation: last_err_count++ (saturating), error_flag<=1.
  - An accepted beat with s_tlast=1 always resets the index to 0 (resync), even when misplaced. Otherwise the index increments, wrapping to 0 after FRAME_LEN-1.
  - FRAME_LEN=1: every beat must carry tlast.
- Per accepted beat: beat_count++; frame_count++ if s_tlast; last_data<=tdata. All counters and flags update on the acceptance edge, one cycle of latency.
- A beat carrying both a data error and a tlast error increments both counters in the same cycle.
- s_tvalid=1 with s_tready=0: no state change except the LFSR.
- Reset mid-frame: all state returns to reset values; the next frame is checked from index 0, and re-seeded again when SYNC_FIRST=1.

Test Plan:
- bp_en=0, SYNC_FIRST=1, source sends 0x05..0x24 (32 beats), tlast on beats 15 and 31 -> beat_count=32, frame_count=2, both error counts 0, last_data=0x24, s_tready constantly 1 after the first post-reset cycle.
- bp_en=1, same 32-beat stream with tvalid held -> identical final counters; s_tready low on about 25% of cycles; no beat lost or duplicated (last_data=0x24).
- Sequence 0x00..0x04, then 0x09, 0x0A -> data_err_count=1 at the 0x09 beat, 0x0A accepted without error, error_flag=1 and stays 1.
- tlast asserted on beat index 7 of a frame, then 16 further clean beats with tlast on the 16th -> last_err_count=1 and the index resyncs, so the next frame gives no further error; frame_count=2.
- DATA_W=8, sequence 0xFE, 0xFF, 0x00, 0x01 -> no data error (wrap-around).
- rst_n pulsed low mid-frame (beat 5) -> all outputs 0 immediately and asynchronously; the next stream starting at an arbitrary value 0x40 with a 16-beat frame gives zero errors.

Source files
------------

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that checks an incrementing data sequence and fixed
// frame boundaries, with optional LFSR backpressure and status counters.
module axis_seq_checker #(
  parameter int          DATA_W     = 8,
  parameter int          FRAME_LEN  = 16,
  parameter bit          SYNC_FIRST = 1'b1,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic              bp_en,
  output logic [31:0]       beat_count,
  output logic [15:0]       frame_count,
  output logic [15:0]       data_err_count,
  output logic [15:0]       last_err_count,
  output logic              error_flag,
  output logic [DATA_W-1:0] last_data
);

  localparam int IDX_W =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE =
    SYNC_FIRST ? SYNC : RUN;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] exp_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [7:0]        lfsr;
  logic              fb;
  logic              accept;
  logic              data_err;
  logic              last_req;
  logic              last_err;

  assign accept   = s_tvalid && s_tready;
  assign fb       = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign last_req = (idx == LAST_IDX);
  assign last_err = accept && (s_tlast != last_req);

  // Any tlast resyncs the frame position; otherwise count and wrap.
  always_comb begin
    idx_next = idx;
    if (accept) begin
      if (s_tlast || last_req) begin
        idx_next = '0;
      end else begin
        idx_next = idx + IDX_W'(1);
      end
    end
  end

  // Backpressure LFSR and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_SEED;
      s_tready <= 1'b0;
    end else begin
      lfsr     <= {lfsr[6:0], fb};
      s_tready <= bp_en ? (lfsr[1:0] != 2'b00) : 1'b1;
    end
  end

  // Sequence FSM state, expected value and frame index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_STATE;
      expected <= '0;
      idx      <= '0;
    end else begin
      state    <= state_next;
      expected <= exp_next;
      idx      <= idx_next;
    end
  end

  // Next state and data check; a mismatch resyncs expected to tdata+1.
  always_comb begin
    state_next = state;
    exp_next   = expected;
    data_err   = 1'b0;
    if (accept) begin
      case (state)
        SYNC: begin
          exp_next   = s_tdata + DATA_W'(1);
          state_next = RUN;
        end
        RUN: begin
          if (s_tdata != expected) begin
            data_err = 1'b1;
            exp_next = s_tdata + DATA_W'(1);
          end else begin
            exp_next = expected + DATA_W'(1);
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // Beat and frame counters plus last accepted data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count  <= '0;
      frame_count <= '0;
      last_data   <= '0;
    end else if (accept) begin
      beat_count <= beat_count + 32'd1;
      last_data  <= s_tdata;
      if (s_tlast) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Saturating error counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_err_count <= '0;
      last_err_count <= '0;
      error_flag     <= 1'b0;
    end else begin
      if (data_err && data_err_count != 16'hFFFF) begin
        data_err_count <= data_err_count + 16'd1;
      end
      if (last_err && last_err_count != 16'hFFFF) begin
        last_err_count <= last_err_count + 16'd1;
      end
      if (data_err || last_err) begin
        error_flag <= 1'b1;
      end
    end
  end

endmodule
